bus_ram_slave: RTL and testbench

- Burst responder on the team's split-channel memory bus (write address/data, read address/data); the counterpart of the UDP bus initiator.
- Backs the bus with an internal synchronous RAM of DEPTH 32-bit words.
- Serves as a low-latency register/buffer target next to the DDR3 slave, and as a DDR3 stand-in for UDP loopback bring-up.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_ram_slave_mem.sv | 38 +++
 rtl/bus_ram_slave.sv | 205 ++++++++++++++++++++
 tb/tb_bus_ram_slave.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the split-channel memory bus: field widths and
// the burst-responder FSM state types.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 28;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_LEN_W  = 8;
  localparam int unsigned BUS_STRB_W = 4;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bus_ram_slave_mem.sv
// Simple dual-port RAM with per-byte write enables and registered,
// read-first output; written so synthesis maps it onto block RAM.
module bus_ram_slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                  i_clk,
  input  logic [BUS_STRB_W-1:0] i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [BUS_DATA_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [BUS_DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Power-up contents only; reset never touches the array.
  logic [BUS_DATA_W-1:0] r_mem [DEPTH] =
    '{default: (INIT_ZERO ? {BUS_DATA_W{1'b0}} : {BUS_DATA_W{1'bx}})};
  logic [BUS_DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < BUS_STRB_W; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_ram_slave.sv
// Burst responder for the split-channel memory bus, backed by an internal RAM.
// Independent write and read FSMs; reads drain through a 2-entry skid buffer.
module bus_ram_slave
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                  BUS_CLK,
  input  logic                  rst_n,
  input  logic [BUS_ADDR_W-1:0] BUS_WR_ADDR,
  input  logic [BUS_LEN_W-1:0]  BUS_WR_LEN,
  input  logic                  BUS_WR_ADDR_VALID,
  output logic                  BUS_WR_ADDR_READY,
  input  logic [BUS_DATA_W-1:0] BUS_WR_DATA,
  input  logic [BUS_STRB_W-1:0] BUS_WR_STRB,
  input  logic                  BUS_WR_DATA_VALID,
  output logic                  BUS_WR_DATA_READY,
  input  logic                  BUS_WR_DATA_LAST,
  input  logic [BUS_ADDR_W-1:0] BUS_RD_ADDR,
  input  logic [BUS_LEN_W-1:0]  BUS_RD_LEN,
  input  logic                  BUS_RD_ADDR_VALID,
  output logic                  BUS_RD_ADDR_READY,
  output logic [BUS_DATA_W-1:0] BUS_RD_DATA,
  output logic                  BUS_RD_DATA_LAST,
  output logic                  BUS_RD_DATA_VALID,
  input  logic                  BUS_RD_DATA_READY,
  output logic                  wr_len_err
);

  // Write channel
  wr_state_e             r_wr_state;
  logic                  r_wr_addr_ready;
  logic                  r_wr_data_ready;
  logic                  r_wr_len_err;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [BUS_LEN_W-1:0]  r_wr_len;
  logic [BUS_LEN_W:0]    r_wr_cnt;
  logic                  w_wr_beat;
  logic                  w_wr_in_len;
  logic                  w_wr_len_bad;
  logic [BUS_STRB_W-1:0] w_mem_we;
  logic [ADDR_W-1:0]     w_mem_waddr;

  // Read channel
  rd_state_e             r_rd_state;
  logic                  r_rd_addr_ready;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [BUS_LEN_W-1:0]  r_rd_len;
  logic [BUS_LEN_W:0]    r_rd_cnt;
  logic                  r_rd_pend;
  logic                  r_rd_pend_last;
  logic [BUS_DATA_W-1:0] r_buf_data [2];
  logic                  r_buf_last [2];
  logic [1:0]            r_buf_cnt;
  logic [BUS_DATA_W-1:0] w_buf_data_d [2];
  logic                  w_buf_last_d [2];
  logic [1:0]            w_buf_cnt_d;
  logic                  w_rd_pop;
  logic                  w_rd_room;
  logic                  w_rd_issue;
  logic [ADDR_W-1:0]     w_mem_raddr;
  logic [BUS_DATA_W-1:0] w_mem_rdata;
  logic                  w_unused;

  assign w_unused = ^{BUS_WR_ADDR[BUS_ADDR_W-1:ADDR_W], BUS_RD_ADDR[BUS_ADDR_W-1:ADDR_W]};

  assign w_wr_beat    = r_wr_data_ready && BUS_WR_DATA_VALID;
  assign w_wr_in_len  = (r_wr_cnt <= {1'b0, r_wr_len});
  assign w_wr_len_bad = !w_wr_in_len || (BUS_WR_DATA_LAST && (r_wr_cnt != {1'b0, r_wr_len}));
  assign w_mem_we     = BUS_WR_STRB & {BUS_STRB_W{w_wr_beat && w_wr_in_len}};
  assign w_mem_waddr  = r_wr_addr + ADDR_W'(r_wr_cnt);

  always_ff @(posedge BUS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state      <= W_IDLE;
      r_wr_addr_ready <= 1'b1;
      r_wr_data_ready <= 1'b0;
      r_wr_len_err    <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_len        <= '0;
      r_wr_cnt        <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (BUS_WR_ADDR_VALID && r_wr_addr_ready) begin
            r_wr_addr       <= BUS_WR_ADDR[ADDR_W-1:0];
            r_wr_len        <= BUS_WR_LEN;
            r_wr_cnt        <= '0;
            r_wr_state      <= W_DATA;
            r_wr_addr_ready <= 1'b0;
            r_wr_data_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wr_beat) begin
            if (w_wr_len_bad) r_wr_len_err <= 1'b1;
            // Saturate so a runaway burst cannot wrap back into the valid range
            if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (BUS_WR_DATA_LAST) begin
              r_wr_state      <= W_IDLE;
              r_wr_addr_ready <= 1'b1;
              r_wr_data_ready <= 1'b0;
            end
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign BUS_WR_ADDR_READY = r_wr_addr_ready;
  assign BUS_WR_DATA_READY = r_wr_data_ready;
  assign wr_len_err        = r_wr_len_err;

  // Issue only if the in-flight read plus buffered beats still fit after this cycle's pop
  assign w_rd_pop    = (r_buf_cnt != 2'd0) && BUS_RD_DATA_READY;
  assign w_rd_room   = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && !r_rd_pend) || w_rd_pop;
  assign w_rd_issue  = (r_rd_state == R_DATA) && (r_rd_cnt <= {1'b0, r_rd_len}) && w_rd_room;
  assign w_mem_raddr = r_rd_addr + ADDR_W'(r_rd_cnt);

  always_ff @(posedge BUS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state      <= R_IDLE;
      r_rd_addr_ready <= 1'b1;
      r_rd_addr       <= '0;
      r_rd_len        <= '0;
      r_rd_cnt        <= '0;
      r_rd_pend       <= 1'b0;
      r_rd_pend_last  <= 1'b0;
    end else begin
      r_rd_pend      <= w_rd_issue;
      r_rd_pend_last <= (r_rd_cnt == {1'b0, r_rd_len});
      case (r_rd_state)
        R_IDLE: begin
          if (BUS_RD_ADDR_VALID && r_rd_addr_ready) begin
            r_rd_addr       <= BUS_RD_ADDR[ADDR_W-1:0];
            r_rd_len        <= BUS_RD_LEN;
            r_rd_cnt        <= '0;
            r_rd_state      <= R_DATA;
            r_rd_addr_ready <= 1'b0;
          end
        end
        R_DATA: begin
          if (w_rd_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_rd_pop && r_buf_last[0]) begin
            r_rd_state      <= R_IDLE;
            r_rd_addr_ready <= 1'b1;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Head is entry 0; vacated entries are zeroed so an empty buffer shows DATA = 0, LAST = 0
  always_comb begin
    w_buf_data_d = r_buf_data;
    w_buf_last_d = r_buf_last;
    w_buf_cnt_d  = r_buf_cnt;
    if (w_rd_pop) begin
      w_buf_data_d[0] = r_buf_data[1];
      w_buf_last_d[0] = r_buf_last[1];
      w_buf_data_d[1] = '0;
      w_buf_last_d[1] = 1'b0;
      w_buf_cnt_d     = r_buf_cnt - 2'd1;
    end
    if (r_rd_pend) begin
      w_buf_data_d[w_buf_cnt_d[0]] = w_mem_rdata;
      w_buf_last_d[w_buf_cnt_d[0]] = r_rd_pend_last;
      w_buf_cnt_d                  = w_buf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge BUS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_data <= '{default: '0};
      r_buf_last <= '{default: 1'b0};
      r_buf_cnt  <= 2'd0;
    end else begin
      r_buf_data <= w_buf_data_d;
      r_buf_last <= w_buf_last_d;
      r_buf_cnt  <= w_buf_cnt_d;
    end
  end

  assign BUS_RD_ADDR_READY = r_rd_addr_ready;
  assign BUS_RD_DATA       = r_buf_data[0];
  assign BUS_RD_DATA_LAST  = r_buf_last[0];
  assign BUS_RD_DATA_VALID = (r_buf_cnt != 2'd0);

  bus_ram_slave_mem #(
    .ADDR_W   (ADDR_W),
    .INIT_ZERO(INIT_ZERO)
  ) u_mem (
    .i_clk  (BUS_CLK),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_waddr),
    .i_wdata(BUS_WR_DATA),
    .i_re   (w_rd_issue),
    .i_raddr(w_mem_raddr),
    .o_rdata(w_mem_rdata)
  );

endmodule

// File: tb/tb_bus_ram_slave.sv
// Self-checking bench for bus_ram_slave: randomized bursts checked against a
// word-array model of the RAM built from the addressing and strobe rules.
module tb_bus_ram_slave;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] BUS_WR_ADDR = '0;
  logic [7:0]  BUS_WR_LEN = '0;
  logic        BUS_WR_ADDR_VALID = 1'b0;
  logic        BUS_WR_ADDR_READY;
  logic [31:0] BUS_WR_DATA = '0;
  logic [3:0]  BUS_WR_STRB = '0;
  logic        BUS_WR_DATA_VALID = 1'b0;
  logic        BUS_WR_DATA_READY;
  logic        BUS_WR_DATA_LAST = 1'b0;
  logic [27:0] BUS_RD_ADDR = '0;
  logic [7:0]  BUS_RD_LEN = '0;
  logic        BUS_RD_ADDR_VALID = 1'b0;
  logic        BUS_RD_ADDR_READY;
  logic [31:0] BUS_RD_DATA;
  logic        BUS_RD_DATA_LAST;
  logic        BUS_RD_DATA_VALID;
  logic        BUS_RD_DATA_READY = 1'b0;
  logic        wr_len_err;

  always #5 clk = ~clk;

  bus_ram_slave #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
    .BUS_CLK(clk), .rst_n(rst_n),
    .BUS_WR_ADDR(BUS_WR_ADDR), .BUS_WR_LEN(BUS_WR_LEN),
    .BUS_WR_ADDR_VALID(BUS_WR_ADDR_VALID), .BUS_WR_ADDR_READY(BUS_WR_ADDR_READY),
    .BUS_WR_DATA(BUS_WR_DATA), .BUS_WR_STRB(BUS_WR_STRB),
    .BUS_WR_DATA_VALID(BUS_WR_DATA_VALID), .BUS_WR_DATA_READY(BUS_WR_DATA_READY),
    .BUS_WR_DATA_LAST(BUS_WR_DATA_LAST),
    .BUS_RD_ADDR(BUS_RD_ADDR), .BUS_RD_LEN(BUS_RD_LEN),
    .BUS_RD_ADDR_VALID(BUS_RD_ADDR_VALID), .BUS_RD_ADDR_READY(BUS_RD_ADDR_READY),
    .BUS_RD_DATA(BUS_RD_DATA), .BUS_RD_DATA_LAST(BUS_RD_DATA_LAST),
    .BUS_RD_DATA_VALID(BUS_RD_DATA_VALID), .BUS_RD_DATA_READY(BUS_RD_DATA_READY),
    .wr_len_err(wr_len_err)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          g_ref_err = 1'b0;
  logic [31:0] g_wdata [0:511];
  logic [3:0]  g_wstrb [0:511];
  logic [31:0] g_rdata [0:511];
  logic        g_rlast [0:511];
  int          g_rcnt, g_rlat, g_rdone, g_runstable, g_rextra;
  logic        g_rardy;

  // Write burst of nbeats beats; the model applies the spec's strobe/length rules.
  task automatic wr_burst(input logic [27:0] addr, input int len, input int nbeats,
                          input bit gaps, output bit tmo);
    int w;
    int idx;
    tmo = 1'b0;
    @(negedge clk);
    BUS_WR_ADDR = addr; BUS_WR_LEN = len[7:0]; BUS_WR_ADDR_VALID = 1'b1;
    w = 0;
    while (!BUS_WR_ADDR_READY && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) tmo = 1'b1;
    @(negedge clk);
    BUS_WR_ADDR_VALID = 1'b0;
    for (int b = 0; b < nbeats && !tmo; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        BUS_WR_DATA_VALID = 1'b0;
        @(negedge clk);
      end
      BUS_WR_DATA = g_wdata[b]; BUS_WR_STRB = g_wstrb[b];
      BUS_WR_DATA_LAST = (b == nbeats - 1); BUS_WR_DATA_VALID = 1'b1;
      w = 0;
      while (!BUS_WR_DATA_READY && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) tmo = 1'b1;
      @(negedge clk);
      if (b <= len) begin
        idx = (int'(addr) + b) % DEPTH;
        for (int i = 0; i < 4; i++)
          if (g_wstrb[b][i]) ref_mem[idx][8*i +: 8] = g_wdata[b][8*i +: 8];
      end
    end
    BUS_WR_DATA_VALID = 1'b0; BUS_WR_DATA_LAST = 1'b0;
    if (nbeats - 1 != len) g_ref_err = 1'b1;
  endtask

  // Read burst: collects accepted beats, first-VALID latency and stall-stability violations.
  task automatic rd_burst(input logic [27:0] addr, input int len, input bit rnd_ready,
                          output bit tmo);
    int w, c;
    logic [31:0] held_d;
    logic held_l;
    bit holding;
    tmo = 1'b0; g_rcnt = 0; g_rlat = -1; g_rdone = -1; g_runstable = 0; g_rextra = 0;
    holding = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    BUS_RD_ADDR = addr; BUS_RD_LEN = len[7:0]; BUS_RD_ADDR_VALID = 1'b1;
    BUS_RD_DATA_READY = 1'b0;
    w = 0;
    while (!BUS_RD_ADDR_READY && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) tmo = 1'b1;
    @(negedge clk);
    BUS_RD_ADDR_VALID = 1'b0;
    c = 0;
    while (g_rcnt <= len && c < 3000 && !tmo) begin
      BUS_RD_DATA_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (BUS_RD_DATA_VALID) begin
        if (g_rlat < 0) g_rlat = c;
        if (holding && (BUS_RD_DATA !== held_d || BUS_RD_DATA_LAST !== held_l)) g_runstable++;
        if (BUS_RD_DATA_READY) begin
          g_rdata[g_rcnt] = BUS_RD_DATA; g_rlast[g_rcnt] = BUS_RD_DATA_LAST;
          g_rcnt++; holding = 1'b0; g_rdone = c;
        end else begin
          holding = 1'b1; held_d = BUS_RD_DATA; held_l = BUS_RD_DATA_LAST;
        end
      end else if (holding) begin
        g_runstable++;
      end
      @(negedge clk);
      c++;
    end
    if (c >= 3000) tmo = 1'b1;
    g_rardy = BUS_RD_ADDR_READY;
    BUS_RD_DATA_READY = 1'b1;
    repeat (4) begin
      if (BUS_RD_DATA_VALID) g_rextra++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    g_ref_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({BUS_WR_ADDR_READY, BUS_RD_ADDR_READY, BUS_WR_DATA_READY, BUS_RD_DATA_VALID,
         BUS_RD_DATA_LAST, wr_len_err} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 110000", {BUS_WR_ADDR_READY, BUS_RD_ADDR_READY,
               BUS_WR_DATA_READY, BUS_RD_DATA_VALID, BUS_RD_DATA_LAST, wr_len_err});
    end
    n_checks++;
    if (BUS_RD_DATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 0", BUS_RD_DATA);
    end
  endtask

  task automatic test_burst();
    bit tmo;
    for (int i = 0; i < 4; i++) begin g_wdata[i] = 32'hA0 + 32'(i); g_wstrb[i] = 4'hF; end
    wr_burst(28'h10, 3, 4, 1'b0, tmo);
    n_checks++;
    if (tmo) begin n_fail++; $display("FAIL burst_write: got timeout want completion"); end
    rd_burst(28'h10, 3, 1'b0, tmo);
    n_checks++;
    if (g_rcnt != 4 || g_rextra != 0) begin
      n_fail++; $display("FAIL burst_count: got %0d (+%0d extra) want 4", g_rcnt, g_rextra);
    end
    n_checks++;
    if (g_rlat != 2) begin n_fail++; $display("FAIL burst_latency: got %0d want 2", g_rlat); end
    n_checks++;
    if (g_rardy !== 1'b1) begin n_fail++; $display("FAIL burst_ardy_after: got %b want 1", g_rardy); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (g_rdata[i] !== 32'hA0 + 32'(i) || g_rlast[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL burst_beat%0d: got %h/%b want %h/%b", i, g_rdata[i], g_rlast[i],
                 32'hA0 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    bit tmo;
    g_wdata[0] = 32'hFFFF_FFFF; g_wstrb[0] = 4'hF;
    wr_burst(28'h5, 0, 1, 1'b0, tmo);
    g_wdata[0] = 32'h1234_5678; g_wstrb[0] = 4'h5;
    wr_burst(28'h5, 0, 1, 1'b0, tmo);
    rd_burst(28'h5, 0, 1'b0, tmo);
    n_checks++;
    if (g_rcnt != 1 || g_rdata[0] !== 32'hFF34_FF78 || g_rlast[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h/%b (%0d beats) want ff34ff78/1", g_rdata[0],
               g_rlast[0], g_rcnt);
    end
  endtask

  task automatic test_ready_stall();
    bit tmo;
    logic [27:0] a;
    a = 28'(32'h80 + $urandom_range(0, 63));
    for (int i = 0; i < 8; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
    wr_burst(a, 7, 8, 1'b1, tmo);
    rd_burst(a, 7, 1'b1, tmo);
    n_checks++;
    if (tmo || g_rcnt != 8 || g_rextra != 0) begin
      n_fail++; $display("FAIL stall_count: got %0d (+%0d extra) want 8", g_rcnt, g_rextra);
    end
    n_checks++;
    if (g_runstable != 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d changes want 0", g_runstable);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (g_rdata[i] !== g_wdata[i] || g_rlast[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, g_rdata[i], g_rlast[i],
                 g_wdata[i], (i == 7));
      end
    end
  endtask

  task automatic test_wrap();
    bit tmo;
    int bad;
    for (int i = 0; i < 4; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
    wr_burst(28'hFFF_FFFE, 3, 4, 1'b0, tmo);
    rd_burst(28'h0, 1, 1'b0, tmo);
    n_checks++;
    if (g_rcnt != 2 || g_rdata[0] !== g_wdata[2] || g_rdata[1] !== g_wdata[3]) begin
      n_fail++;
      $display("FAIL wrap_low: got %h %h want %h %h", g_rdata[0], g_rdata[1], g_wdata[2],
               g_wdata[3]);
    end
    rd_burst(28'(DEPTH - 2), 3, 1'b1, tmo);
    bad = 0;
    for (int i = 0; i < 4; i++) if (g_rdata[i] !== g_wdata[i]) bad++;
    n_checks++;
    if (g_rcnt != 4 || bad != 0) begin
      n_fail++; $display("FAIL wrap_span: got %0d beats %0d wrong want 4 beats 0 wrong", g_rcnt, bad);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    logic [27:0] a;
    int len, rlen, bad;
    for (int it = 0; it < 6; it++) begin
      a = 28'($urandom);
      len = $urandom_range(0, 20);
      for (int i = 0; i <= len; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'($urandom); end
      wr_burst(a, len, len + 1, 1'b1, tmo);
      rlen = $urandom_range(0, 24);
      rd_burst(a, rlen, 1'b1, tmo);
      bad = 0;
      for (int i = 0; i <= rlen; i++)
        if (g_rdata[i] !== ref_mem[(int'(a) + i) % DEPTH] || g_rlast[i] !== (i == rlen)) bad++;
      n_checks++;
      if (tmo || g_rcnt != rlen + 1 || bad != 0 || g_runstable != 0 || g_rextra != 0) begin
        n_fail++;
        $display("FAIL b2b_iter%0d: got %0d beats %0d wrong %0d unstable want %0d/0/0",
                 it, g_rcnt, bad, g_runstable, rlen + 1);
      end
    end
    a = 28'($urandom);
    rd_burst(a, 255, 1'b0, tmo);
    bad = 0;
    for (int i = 0; i <= 255; i++)
      if (g_rdata[i] !== ref_mem[(int'(a) + i) % DEPTH] || g_rlast[i] !== (i == 255)) bad++;
    n_checks++;
    if (g_rcnt != 256 || bad != 0) begin
      n_fail++; $display("FAIL len255_data: got %0d beats %0d wrong want 256/0", g_rcnt, bad);
    end
    n_checks++;
    if (g_rdone - g_rlat != 255) begin
      n_fail++; $display("FAIL len255_rate: got %0d cycles want 255", g_rdone - g_rlat);
    end
    n_checks++;
    if (wr_len_err !== g_ref_err) begin
      n_fail++; $display("FAIL b2b_len_err: got %b want %b", wr_len_err, g_ref_err);
    end
  endtask

  task automatic test_concurrent();
    bit t1, t2;
    int bad;
    for (int i = 0; i < 16; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
    wr_burst(28'h100, 15, 16, 1'b0, t1);
    for (int i = 0; i < 16; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'($urandom); end
    fork
      wr_burst(28'h200, 15, 16, 1'b1, t1);
      rd_burst(28'h100, 15, 1'b1, t2);
    join
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_rdata[i] !== ref_mem[256 + i]) bad++;
    n_checks++;
    if (t1 || t2 || g_rcnt != 16 || bad != 0 || g_runstable != 0) begin
      n_fail++;
      $display("FAIL conc_read: got %0d beats %0d wrong tmo %b%b want 16/0/00", g_rcnt, bad, t1, t2);
    end
    rd_burst(28'h200, 15, 1'b0, t2);
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_rdata[i] !== ref_mem[512 + i]) bad++;
    n_checks++;
    if (g_rcnt != 16 || bad != 0) begin
      n_fail++; $display("FAIL conc_write: got %0d beats %0d wrong want 16/0", g_rcnt, bad);
    end
  endtask

  task automatic test_len_err();
    bit tmo;
    logic [31:0] old;
    int bad;
    g_wdata[0] = $urandom; g_wstrb[0] = 4'hF;
    wr_burst(28'h40, 1, 1, 1'b0, tmo);
    n_checks++;
    if (wr_len_err !== 1'b1 || BUS_WR_ADDR_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL lenerr_early: got err %b ardy %b want 1 1", wr_len_err, BUS_WR_ADDR_READY);
    end
    old = ref_mem[32'h54];
    for (int i = 0; i < 5; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
    g_wdata[4] = ~old;
    wr_burst(28'h50, 3, 5, 1'b1, tmo);
    rd_burst(28'h50, 4, 1'b1, tmo);
    n_checks++;
    if (g_rcnt != 5 || g_rdata[4] !== old) begin
      n_fail++; $display("FAIL lenerr_overrun: got %h want %h", g_rdata[4], old);
    end
    rd_burst(28'h40, 1, 1'b0, tmo);
    bad = 0;
    for (int i = 0; i < 2; i++) if (g_rdata[i] !== ref_mem[64 + i]) bad++;
    n_checks++;
    if (g_rcnt != 2 || bad != 0 || wr_len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lenerr_short: got %0d beats %0d wrong err %b want 2/0/1", g_rcnt, bad, wr_len_err);
    end
  endtask

  task automatic test_reset_mid_read();
    bit tmo;
    int acc, c, stale, bad;
    for (int i = 0; i < 8; i++) begin g_wdata[i] = $urandom; g_wstrb[i] = 4'hF; end
    wr_burst(28'h300, 7, 8, 1'b0, tmo);
    @(negedge clk);
    BUS_RD_ADDR = 28'h300; BUS_RD_LEN = 8'd7; BUS_RD_ADDR_VALID = 1'b1; BUS_RD_DATA_READY = 1'b1;
    c = 0;
    while (!BUS_RD_ADDR_READY && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    BUS_RD_ADDR_VALID = 1'b0;
    acc = 0; c = 0;
    while (acc < 2 && c < 50) begin
      if (BUS_RD_DATA_VALID) acc++;
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (BUS_RD_DATA_VALID !== 1'b1 || BUS_RD_DATA !== g_wdata[2]) begin
      n_fail++;
      $display("FAIL midrst_beat3: got %b/%h want 1/%h", BUS_RD_DATA_VALID, BUS_RD_DATA, g_wdata[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({BUS_RD_DATA_VALID, BUS_RD_DATA_LAST, BUS_RD_DATA} !== 34'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got %b/%b/%h want 0/0/0", BUS_RD_DATA_VALID,
               BUS_RD_DATA_LAST, BUS_RD_DATA);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g_ref_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({BUS_WR_ADDR_READY, BUS_RD_ADDR_READY, BUS_WR_DATA_READY, BUS_RD_DATA_VALID,
         wr_len_err} !== 5'b11000) begin
      n_fail++;
      $display("FAIL midrst_release: got %b want 11000", {BUS_WR_ADDR_READY, BUS_RD_ADDR_READY,
               BUS_WR_DATA_READY, BUS_RD_DATA_VALID, wr_len_err});
    end
    stale = 0;
    repeat (6) begin
      if (BUS_RD_DATA_VALID) stale++;
      @(negedge clk);
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d beats want 0", stale); end
    rd_burst(28'h300, 7, 1'b1, tmo);
    bad = 0;
    for (int i = 0; i < 8; i++) if (g_rdata[i] !== g_wdata[i]) bad++;
    n_checks++;
    if (g_rcnt != 8 || bad != 0) begin
      n_fail++; $display("FAIL midrst_ram_kept: got %0d beats %0d wrong want 8/0", g_rcnt, bad);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_burst();
    test_strobe();
    test_ready_stall();
    test_wrap();
    test_back_to_back();
    test_concurrent();
    test_len_err();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
